wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single GPR write port between two result lanes: lane 0 carries delayed-execute ALU results, lane 1 carries memory-stage load results. Each lane has a small in-order FIFO. A round-robin arbiter drains one entry per cycle into a registered write-port output. The block also reports pending-write hazards on two source-register query ports so issue logic can stall.

## Interface
Parameters:
- DEPTH, 2, entries per lane FIFO; power of two, ≥2
- DATA_W, 32, width of write data and debug address

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard all buffered and registered writes
- in0_valid / in1_valid  in  1  lane offers an entry
- in0_ready / in1_ready  out  1  lane FIFO not full
- in0_num / in1_num  in  5  destination GPR; 0 means no write
- in0_data / in1_data  in  DATA_W  write data
- in0_vaddr / in1_vaddr  in  DATA_W  instruction address, for debug trace
- wb_valid  out  1  write-port strobe
- wb_num  out  5  GPR written
- wb_data  out  DATA_W  write data
- wb_vaddr  out  DATA_W  address of the retiring instruction
- wb_lane  out  1  lane that produced the current write
- q_rs / q_rt  in  5  source registers queried by issue
- hit_rs / hit_rt  out  1  a pending write targets the queried register
- conflict_cnt  out  16  cycles in which both lanes contended (see Configuration)

## Operation
- Accept: a lane entry is accepted when inX_valid && inX_ready && !flush.
  - inX_ready = (count < DEPTH). It is computed from the registered count only, so a full FIFO is not ready even in a cycle where it pops.
  - An accepted entry with num==0 is consumed but not enqueued.
- FIFO: per lane, a circular buffer with a wrapping read/write pointer of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Push and pop in the same cycle leave count unchanged. Order is preserved within a lane. No ordering is enforced across lanes.
- Arbitration: each cycle the arbiter considers the FIFO heads.
  - One head valid: grant it.
  - Both heads valid: grant the lane != last_grant.
  - last_grant updates only on a grant.
  - The granted head pops, and its fields load the output register.
- Output register: wb_valid = 1 for one cycle per granted entry; otherwise wb_valid = 0. When wb_valid = 0, wb_num/wb_data/wb_vaddr/wb_lane hold their last values.
- Hazard: hit_rs = (q_rs != 0) && (q_rs matches the num of any valid entry in either FIFO, or wb_num while wb_valid). hit_rt is computed the same way. Both are combinational.
- Flush: clears both FIFOs (pointers and counts to 0) and wb_valid. Flush wins over any same-cycle accept or grant; those entries are lost. last_grant is not changed by flush.

## Timing
- Reset values: wb_valid=0, wb_num=0, wb_data=0, wb_vaddr=0, wb_lane=0, last_grant=1 (lane 0 wins the first tie), both FIFOs empty, inX_ready=1, hit_*=0, conflict_cnt=0.
- Latency: an entry accepted in cycle N into an empty, uncontended lane is granted in N+1 and appears with wb_valid in N+2.
- Throughput: one write per cycle total. With both lanes saturated, the lanes alternate every cycle.
- The write port never back-pressures: the output register updates every cycle.
- Reset mid-operation: all buffered writes are dropped, and outputs take their reset values on the next edge.

## Configuration
- WB_ARB_STATS_EN defined:
  - conflict_cnt increments in every cycle with both heads valid and !flush.
  - It saturates at 16'hFFFF and is cleared only by rst.
- WB_ARB_STATS_EN undefined: conflict_cnt is tied to 0 and no counter logic is built.
- Arbitration behaviour is identical in both builds.

## Test plan
- Single lane: lane 0 pushes num=5, data=0x11 in cycle 1 → wb_valid, wb_num=5, wb_data=0x11, wb_lane=0 in cycle 3; hit_rs with q_rs=5 is high in cycles 2–3.
- Contention: both lanes push every cycle after reset → wb_lane sequence 0,1,0,1…; no entry is lost or reordered within a lane; with stats enabled, conflict_cnt counts the contended cycles.
- Full: lane 1 pushes DEPTH+1 entries back-to-back while lane 0 holds priority → in1_ready=0 in exactly the cycle count==DEPTH; the extra entry is accepted only after a pop.
- Zero register: push num=0 on lane 0 → accepted (ready stays high), no wb_valid ever; q_rs=0 never hits.
- Flush: fill both FIFOs, assert flush together with new valid inputs → next cycle counts=0, wb_valid=0, hits=0; the same-cycle inputs never appear on the write port.
- Reset mid-stream: assert rst with entries pending → all outputs at reset values next cycle; the first tie afterwards grants lane 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Two-lane GPR write-port arbiter: per-lane in-order FIFOs, round-robin drain, pending-write hazards.
// Define WB_ARB_STATS_EN to build the saturating contention counter on conflict_cnt_o.
module wb_port_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in0_valid_i,
    output logic              in0_ready_o,
    input  logic [4:0]        in0_num_i,
    input  logic [DATA_W-1:0] in0_data_i,
    input  logic [DATA_W-1:0] in0_vaddr_i,
    input  logic              in1_valid_i,
    output logic              in1_ready_o,
    input  logic [4:0]        in1_num_i,
    input  logic [DATA_W-1:0] in1_data_i,
    input  logic [DATA_W-1:0] in1_vaddr_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_num_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [DATA_W-1:0] wb_vaddr_o,
    output logic              wb_lane_o,
    input  logic [4:0]        q_rs_i,
    input  logic [4:0]        q_rt_i,
    output logic              hit_rs_o,
    output logic              hit_rt_o,
    output logic [15:0]       conflict_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [1:0]        in_valid, in_ready, push, pop, head_vld;
    logic [4:0]        in_num   [2];
    logic [DATA_W-1:0] in_data  [2];
    logic [DATA_W-1:0] in_vaddr [2];

    logic [4:0]        num_q   [2][DEPTH];
    logic [DATA_W-1:0] data_q  [2][DEPTH];
    logic [DATA_W-1:0] vaddr_q [2][DEPTH];

    logic [PtrW-1:0] wptr_q [2];
    logic [PtrW-1:0] wptr_d [2];
    logic [PtrW-1:0] rptr_q [2];
    logic [PtrW-1:0] rptr_d [2];
    logic [CntW-1:0] cnt_q  [2];
    logic [CntW-1:0] cnt_d  [2];

    logic last_grant_q;
    logic grant_vld, grant_lane;

    logic              wb_valid_q, wb_lane_q;
    logic [4:0]        wb_num_q;
    logic [DATA_W-1:0] wb_data_q, wb_vaddr_q;

    logic [PtrW-1:0] offs;
    logic            hit_rs, hit_rt;

    assign in_valid    = {in1_valid_i, in0_valid_i};
    assign in_num[0]   = in0_num_i;
    assign in_num[1]   = in1_num_i;
    assign in_data[0]  = in0_data_i;
    assign in_data[1]  = in1_data_i;
    assign in_vaddr[0] = in0_vaddr_i;
    assign in_vaddr[1] = in1_vaddr_i;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            in_ready[l] = cnt_q[l] < FullCnt;
            head_vld[l] = cnt_q[l] != '0;
            // num==0 entries are consumed without occupying a slot
            push[l]     = in_valid[l] && in_ready[l] && !flush_i && (in_num[l] != 5'd0);
        end
    end

    always_comb begin
        grant_vld = (|head_vld) && !flush_i;
        if (&head_vld) begin
            grant_lane = ~last_grant_q;
        end else begin
            grant_lane = head_vld[1];
        end
        pop = '0;
        if (grant_vld) begin
            pop[grant_lane] = 1'b1;
        end
    end

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            wptr_d[l] = wptr_q[l];
            rptr_d[l] = rptr_q[l];
            cnt_d[l]  = cnt_q[l];
            if (flush_i) begin
                wptr_d[l] = '0;
                rptr_d[l] = '0;
                cnt_d[l]  = '0;
            end else begin
                if (push[l]) wptr_d[l] = wptr_q[l] + PtrW'(1);
                if (pop[l])  rptr_d[l] = rptr_q[l] + PtrW'(1);
                unique case ({push[l], pop[l]})
                    2'b10:   cnt_d[l] = cnt_q[l] + CntW'(1);
                    2'b01:   cnt_d[l] = cnt_q[l] - CntW'(1);
                    default: cnt_d[l] = cnt_q[l];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                num_q[l][wptr_q[l]]   <= in_num[l];
                data_q[l][wptr_q[l]]  <= in_data[l];
                vaddr_q[l][wptr_q[l]] <= in_vaddr[l];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int l = 0; l < 2; l++) begin
                wptr_q[l] <= '0;
                rptr_q[l] <= '0;
                cnt_q[l]  <= '0;
            end
            last_grant_q <= 1'b1;
            wb_valid_q   <= 1'b0;
            wb_lane_q    <= 1'b0;
            wb_num_q     <= '0;
            wb_data_q    <= '0;
            wb_vaddr_q   <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                wptr_q[l] <= wptr_d[l];
                rptr_q[l] <= rptr_d[l];
                cnt_q[l]  <= cnt_d[l];
            end
            wb_valid_q <= grant_vld;
            if (grant_vld) begin
                last_grant_q <= grant_lane;
                wb_lane_q    <= grant_lane;
                wb_num_q     <= num_q[grant_lane][rptr_q[grant_lane]];
                wb_data_q    <= data_q[grant_lane][rptr_q[grant_lane]];
                wb_vaddr_q   <= vaddr_q[grant_lane][rptr_q[grant_lane]];
            end
        end
    end

    // An entry slot is live when its distance from the read pointer is below the count.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        offs   = '0;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                offs = PtrW'(i) - rptr_q[l];
                if ({1'b0, offs} < cnt_q[l]) begin
                    if (num_q[l][i] == q_rs_i) hit_rs = 1'b1;
                    if (num_q[l][i] == q_rt_i) hit_rt = 1'b1;
                end
            end
        end
        if (wb_valid_q && (wb_num_q == q_rs_i)) hit_rs = 1'b1;
        if (wb_valid_q && (wb_num_q == q_rt_i)) hit_rt = 1'b1;
    end

    assign hit_rs_o    = hit_rs && (q_rs_i != 5'd0);
    assign hit_rt_o    = hit_rt && (q_rt_i != 5'd0);
    assign in0_ready_o = in_ready[0];
    assign in1_ready_o = in_ready[1];
    assign wb_valid_o  = wb_valid_q;
    assign wb_lane_o   = wb_lane_q;
    assign wb_num_o    = wb_num_q;
    assign wb_data_o   = wb_data_q;
    assign wb_vaddr_o  = wb_vaddr_q;

`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else if ((&head_vld) && !flush_i && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised scoreboard bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [4:0]        num;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] vaddr;
    } ent_t;

    typedef struct packed {
        logic              lane;
        logic [4:0]        num;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] vaddr;
    } wb_t;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic              in0_valid, in0_ready, in1_valid, in1_ready;
    logic [4:0]        in0_num, in1_num;
    logic [DATA_W-1:0] in0_data, in0_vaddr, in1_data, in1_vaddr;
    logic              wb_valid, wb_lane;
    logic [4:0]        wb_num;
    logic [DATA_W-1:0] wb_data, wb_vaddr;
    logic [4:0]        q_rs, q_rt;
    logic              hit_rs, hit_rt;
    logic [15:0]       conflict_cnt;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in0_valid_i    (in0_valid),
        .in0_ready_o    (in0_ready),
        .in0_num_i      (in0_num),
        .in0_data_i     (in0_data),
        .in0_vaddr_i    (in0_vaddr),
        .in1_valid_i    (in1_valid),
        .in1_ready_o    (in1_ready),
        .in1_num_i      (in1_num),
        .in1_data_i     (in1_data),
        .in1_vaddr_i    (in1_vaddr),
        .wb_valid_o     (wb_valid),
        .wb_num_o       (wb_num),
        .wb_data_o      (wb_data),
        .wb_vaddr_o     (wb_vaddr),
        .wb_lane_o      (wb_lane),
        .q_rs_i         (q_rs),
        .q_rt_i         (q_rt),
        .hit_rs_o       (hit_rs),
        .hit_rt_o       (hit_rt),
        .conflict_cnt_o (conflict_cnt)
    );

    // Reference model state
    ent_t        mq0[$];
    ent_t        mq1[$];
    wb_t         sb[$];
    logic        m_last, m_wbv;
    logic [4:0]  m_wbnum;
    logic [15:0] m_cnt;

    // Expected observable values for the current cycle
    logic        exp_rdy0, exp_rdy1, exp_hrs, exp_hrt, exp_wbv;
    logic [15:0] exp_cnt;

    int   n_tests, n_fail;
    bit   chk_en;
    logic rst_prev;
    wb_t  last;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hit(input logic [4:0] q);
        logic h;
        h = 1'b0;
        if (q == 5'd0) return 1'b0;
        foreach (mq0[i]) if (mq0[i].num == q) h = 1'b1;
        foreach (mq1[i]) if (mq1[i].num == q) h = 1'b1;
        if (m_wbv && m_wbnum == q) h = 1'b1;
        return h;
    endfunction

    // Publish this cycle's expectations, advance the model across the edge, then wait for it.
    task automatic step();
        bit   a0, a1, h0, h1, g;
        ent_t e;
        wb_t  w;
        exp_rdy0 = mq0.size() < DEPTH;
        exp_rdy1 = mq1.size() < DEPTH;
        exp_hrs  = model_hit(q_rs);
        exp_hrt  = model_hit(q_rt);
        exp_wbv  = m_wbv;
        exp_cnt  = m_cnt;
        a0 = in0_valid && exp_rdy0 && !flush && in0_num != 5'd0;
        a1 = in1_valid && exp_rdy1 && !flush && in1_num != 5'd0;
        if (rst) begin
            mq0.delete();
            mq1.delete();
            m_last  = 1'b1;
            m_wbv   = 1'b0;
            m_wbnum = '0;
            m_cnt   = '0;
        end else if (flush) begin
            mq0.delete();
            mq1.delete();
            m_wbv = 1'b0;
        end else begin
            h0 = mq0.size() > 0;
            h1 = mq1.size() > 0;
            if (h0 && h1) begin
`ifdef WB_ARB_STATS_EN
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
                g = !m_last;
            end else begin
                g = h1;
            end
            if (h0 || h1) begin
                e = g ? mq1.pop_front() : mq0.pop_front();
                w = '{lane: g, num: e.num, data: e.data, vaddr: e.vaddr};
                sb.push_back(w);
                m_last  = g;
                m_wbv   = 1'b1;
                m_wbnum = e.num;
            end else begin
                m_wbv = 1'b0;
            end
            if (a0) mq0.push_back('{num: in0_num, data: in0_data, vaddr: in0_vaddr});
            if (a1) mq1.push_back('{num: in1_num, data: in1_data, vaddr: in1_vaddr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input int pv0, input int pv1, input int nmax, input bit nz);
        in0_valid = ($urandom_range(99) < pv0);
        in1_valid = ($urandom_range(99) < pv1);
        in0_num   = 5'($urandom_range(nmax));
        in1_num   = 5'($urandom_range(nmax));
        if (nz && in0_num == 5'd0) in0_num = 5'd1;
        if (nz && in1_num == 5'd0) in1_num = 5'd2;
        in0_data  = $urandom;
        in1_data  = $urandom;
        in0_vaddr = $urandom;
        in1_vaddr = $urandom;
        q_rs      = 5'($urandom_range(nmax));
        q_rt      = 5'($urandom_range(nmax));
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        flush     = 1'b0;
    endtask

    // Monitor: lane-order scoreboard on every write strobe plus per-cycle status checks.
    always @(negedge clk) begin
        wb_t w;
        if (chk_en) begin
            if (rst_prev) last = '0;
            check("in0_ready", in0_ready, exp_rdy0);
            check("in1_ready", in1_ready, exp_rdy1);
            check("hit_rs", hit_rs, exp_hrs);
            check("hit_rt", hit_rt, exp_hrt);
            check("wb_valid", wb_valid, exp_wbv);
            check("conflict_cnt", conflict_cnt, exp_cnt);
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got write num %0d with none pending", wb_num);
                end else begin
                    w = sb.pop_front();
                    check("wb_entry", {wb_lane, wb_num, wb_data, wb_vaddr}, w);
                    last = w;
                end
            end else begin
                check("wb_hold", {wb_lane, wb_num, wb_data, wb_vaddr}, last);
            end
        end
        rst_prev = rst;
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst_prev = 1'b1;
        last    = '0;
        m_last  = 1'b1;
        m_wbv   = 1'b0;
        m_wbnum = '0;
        m_cnt   = '0;
        rst     = 1'b1;
        idle_inputs();
        in0_num = '0; in1_num = '0;
        in0_data = '0; in1_data = '0; in0_vaddr = '0; in1_vaddr = '0;
        q_rs = 5'd5; q_rt = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // Single lane: num=5, data=0x11
        in0_valid = 1'b1; in0_num = 5'd5; in0_data = 32'h11; in0_vaddr = 32'h1000;
        step();
        in0_valid = 1'b0;
        repeat (4) step();

        // Zero register writes are swallowed
        in0_valid = 1'b1; in0_num = 5'd0; q_rs = 5'd0; q_rt = 5'd0;
        repeat (3) step();
        idle_inputs();
        repeat (2) step();

        // Both lanes saturated
        for (int i = 0; i < 40; i++) begin
            rand_inputs(100, 100, 31, 1'b1);
            step();
        end
        idle_inputs();
        repeat (4) step();

        // Lane 1 pushes DEPTH+1 back-to-back against a busy lane 0
        for (int i = 0; i < int'(DEPTH) + 3; i++) begin
            rand_inputs(100, (i < int'(DEPTH) + 1) ? 100 : 0, 7, 1'b1);
            step();
        end
        idle_inputs();
        repeat (4) step();

        // Flush over full FIFOs with same-cycle inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs(100, 100, 7, 1'b1);
            step();
        end
        rand_inputs(100, 100, 7, 1'b1);
        flush = 1'b1;
        step();
        idle_inputs();
        repeat (3) step();

        // Reset mid-stream, then the first tie goes to lane 0
        for (int i = 0; i < 3; i++) begin
            rand_inputs(100, 100, 7, 1'b1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_inputs(100, 100, 7, 1'b1);
            step();
        end

        // Free-running random traffic with sporadic flush and reset
        for (int i = 0; i < 400; i++) begin
            rand_inputs(70, 60, 7, 1'b0);
            flush = ($urandom_range(99) < 3);
            rst   = ($urandom_range(99) < 2);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (8) step();

        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
